// File: rtl/la_test_sequencer.sv
// Logic-analyzer driven test sequencer: counts N cycles after a go edge and
// reports start/pass/fail/abort signatures on the LA readback and GPIO.
module la_test_sequencer #(
  parameter logic [15:0] SIG_START = 16'hAB40,
  parameter logic [15:0] SIG_PASS  = 16'hAB51,
  parameter logic [15:0] SIG_FAIL  = 16'hAB5F,
  parameter logic [15:0] SIG_ABORT = 16'hAB5E
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  output logic [37:0]  io_out,
  output logic [37:0]  io_oeb
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ST_W  = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_PASS  = 3'd2,
    ST_FAIL  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [15:0]        ck_q, ck_d;
  logic               go_q, go_d;
  logic               armed_q, armed_d;

  logic               cmd_valid;
  logic               go;
  logic               stall;
  logic               start;
  logic [CNT_W-1:0]   n_cmd;

  // Command decode from the LA probe bits
  assign cmd_valid = (la_oenb[63:32] == 32'h0);
  assign go        = la_data_in[63] & cmd_valid;
  assign n_cmd     = la_data_in[47:32];
  assign stall     = la_data_in[64] & ~la_oenb[64];
  // armed_q blocks a start from a go that was already high through reset
  assign start     = go & ~go_q & armed_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    ck_d    = ck_q;
    go_d    = go;
    armed_d = armed_q | ~go;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (n_cmd != '0) begin
            n_d     = n_cmd;
            cnt_d   = '0;
            ck_d    = SIG_START;
            state_d = ST_RUN;
          end else begin
            ck_d    = SIG_FAIL;
            state_d = ST_FAIL;
          end
        end
      end
      ST_RUN: begin
        if (!go) begin
          ck_d    = SIG_ABORT;
          state_d = ST_ABORT;
        end else if (stall) begin
          state_d = ST_RUN;
        end else if (cnt_q == n_q - CNT_W'(1)) begin
          ck_d    = SIG_PASS;
          state_d = ST_PASS;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_PASS, ST_FAIL, ST_ABORT: begin
        if (!go) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      ck_q    <= '0;
      go_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      ck_q    <= ck_d;
      go_q    <= go_d;
      armed_q <= armed_d;
    end
  end

  // Outputs are pure functions of registered state
  assign la_data_out = {90'd0,
                        (state_q == ST_FAIL) || (state_q == ST_ABORT),
                        state_q == ST_PASS,
                        state_q == ST_RUN,
                        ST_W'(state_q), ck_q, cnt_q};
  assign io_out = {6'd0, ck_q, 16'd0};
  assign io_oeb = {6'h3F, 16'h0000, 16'hFFFF};

  logic unused_inputs;
  assign unused_inputs = ^{la_data_in[127:65], la_data_in[62:48], la_data_in[31:0],
                           la_oenb[127:65], la_oenb[31:0]};

endmodule
